// File: rtl/signed_seq_divider.sv
// signed_seq_divider: restoring signed divider, one step per clock, truncating semantics.
// Optional DIVZERO_DETECT_EN short-circuits a zero divisor straight to DONE.
module signed_seq_divider #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             overflow,
  output logic             div_by_zero
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, CALC, SIGN, DONE} state_t;
  state_t state, next;
  logic [WIDTH:0] acc, acc_sh;
  logic [WIDTH-1:0] qreg, mag_d, mag_n, mag_v;
  logic [CW-1:0] count;
  logic neg_q, neg_r, fit, dz;
`ifdef DIVZERO_DETECT_EN
  assign dz = divisor == '0;
`else
  assign dz = 1'b0;
`endif
  assign mag_n = dividend[WIDTH-1] ? -dividend : dividend;
  assign mag_v = divisor[WIDTH-1] ? -divisor : divisor;
  assign acc_sh = {acc[WIDTH-1:0], qreg[WIDTH-1]};
  assign fit = acc_sh >= {1'b0, mag_d};
  assign busy = state != IDLE;
  assign done = state == DONE;
  always_comb begin
    next = state == IDLE ? (start ? (dz ? DONE : CALC) : IDLE) :
           state == CALC ? (count == '0 ? SIGN : CALC) :
           state == SIGN ? DONE : IDLE;
  end
  always_ff @(posedge clk) state <= reset ? IDLE : next;
  always_ff @(posedge clk) begin
    if (reset) begin
      acc <= '0;
      qreg <= '0;
      mag_d <= '0;
      count <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      quotient <= '0;
      remainder <= '0;
      overflow <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          acc <= '0;
          qreg <= mag_n;
          mag_d <= mag_v;
          count <= CW'(WIDTH - 1);
          neg_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
          neg_r <= dividend[WIDTH-1];
          if (dz) begin
            quotient <= '1;
            remainder <= dividend;
            overflow <= 1'b0;
            div_by_zero <= 1'b1;
          end
        end
        CALC: begin
          acc <= fit ? acc_sh - {1'b0, mag_d} : acc_sh;
          qreg <= {qreg[WIDTH-2:0], fit};
          count <= count - CW'(1);
        end
        SIGN: begin
          quotient <= neg_q ? -qreg : qreg;
          remainder <= neg_r ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
          // only an unsigned-magnitude quotient with MSB set cannot be represented
          overflow <= !neg_q && qreg[WIDTH-1];
          div_by_zero <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_signed_seq_divider.sv
// tb_signed_seq_divider: random and directed checks of signed_seq_divider against an integer model.
module tb_signed_seq_divider;
  localparam int W = 4;
  localparam int MINV = -(1 << (W - 1));
  localparam int MAXV = (1 << (W - 1)) - 1;
`ifdef DIVZERO_DETECT_EN
  localparam bit DET = 1'b1;
`else
  localparam bit DET = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic [W-1:0] dividend = '0, divisor = '0;
  logic busy, done, overflow, div_by_zero;
  logic [W-1:0] quotient, remainder;
  int errors = 0, checks = 0;

  signed_seq_divider #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .overflow(overflow), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic op(input int a, input int b, input bit mid);
    int q, r, ov, dz, lat, n;
    logic [W-1:0] qe, re;
    if (b == 0) begin
      q = DET ? -1 : (a >= 0 ? -1 : 1);
      r = a;
      ov = (!DET && a >= 0) ? 1 : 0;
      dz = DET ? 1 : 0;
      lat = DET ? 0 : W + 1;
    end else begin
      q = a / b;
      r = a % b;
      ov = (a == MINV && b == -1) ? 1 : 0;
      dz = 0;
      lat = W + 1;
    end
    qe = q[W-1:0];
    re = r[W-1:0];
    @(negedge clk);
    dividend = a[W-1:0];
    divisor = b[W-1:0];
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check("busy", busy, 1);
    n = 0;
    while (!done && n < 20) begin
      if (mid && n == 2) begin
        start = 1'b1;
        dividend = W'($urandom);
        divisor = W'($urandom);
      end else start = 1'b0;
      @(posedge clk);
      #1 n++;
    end
    start = 1'b0;
    check($sformatf("latency %0d/%0d", a, b), n, lat);
    check($sformatf("quotient %0d/%0d", a, b), quotient, qe);
    check($sformatf("remainder %0d/%0d", a, b), remainder, re);
    check($sformatf("overflow %0d/%0d", a, b), overflow, ov);
    check($sformatf("div_by_zero %0d/%0d", a, b), div_by_zero, dz);
    @(posedge clk);
    #1 check("done_pulse", done, 0);
    check("idle_busy", busy, 0);
    check("held_quotient", quotient, qe);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_quotient", quotient, 0);
    check("rst_remainder", remainder, 0);
    check("rst_overflow", overflow, 0);
    check("rst_dz", div_by_zero, 0);
    reset = 1'b0;
    op(7, 2, 0);
    op(-7, 2, 0);
    op(7, -2, 0);
    op(-8, -1, 0);
    op(3, 3, 0);
    op(5, 0, 0);
    op(-5, 0, 0);
    op(-8, 0, 0);
    op(-8, 1, 0);
    op(7, 7, 1);
    // abort an operation mid-CALC
    @(negedge clk);
    dividend = 4'd6;
    divisor = 4'd4;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_quotient", quotient, 0);
    check("abort_remainder", remainder, 0);
    check("abort_overflow", overflow, 0);
    check("abort_dz", div_by_zero, 0);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1 check("abort_no_done", done, 0);
    end
    op(-6, 4, 0);
    for (int i = 0; i < 60; i++)
      op(MINV + int'($urandom_range(MAXV - MINV)), MINV + int'($urandom_range(MAXV - MINV)), i % 7 == 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
